reg_dump_tx: RTL
================

# reg_dump_tx

Debug-side transmitter that reads the pipelined core's register file through its debug port and streams a snapshot out over a UART (8N1) line. When triggered, it captures the core's fetch PC and steps the core's `debug_inp` select through all 16 registers. For each register it samples `debug_out` and serialises the results as a framed, checksummed byte stream. It sits beside `top_level` on the FPGA board, driving `debug_inp` and consuming `debug_out` and `fetchPC`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `SETTLE_CYCLES`, default 2: cycles `debug_inp` is held stable before `debug_out` is sampled. Must be ≥ 1.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: level-sampled trigger; accepted only in IDLE.
- `debug_out`, input, 32: register value from the core for the current `debug_inp`.
- `fetchPC`, input, 32: core fetch PC.
- `debug_inp`, output, 4: register select driven to the core.
- `tx`, output, 1: UART serial line; idle high.
- `busy`, output, 1: high from acceptance of `start` until the frame completes.
- `done`, output, 1: one-cycle pulse after the final stop bit.

## Operation
- Frame contents, 70 bytes in order:
  - Header `0xA5`.
  - `fetchPC` as 4 bytes, MSB first.
  - R0..R15, each as 4 bytes, MSB first.
  - Checksum byte.
- Checksum: XOR of all 68 bytes between the header and the checksum (PC bytes and register bytes).
- `fetchPC` is latched on the cycle `start` is accepted. Later PC changes do not affect the frame.
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Top FSM states: IDLE → HDR → PC → (SEL → SETTLE → CAPTURE → WORD) ×16 → CHK → DONE → IDLE.
  - SEL: drive `debug_inp` = register index r. Lasts 1 cycle.
  - SETTLE: hold `debug_inp`. Lasts `SETTLE_CYCLES` cycles.
  - CAPTURE: latch `debug_out` into a 32-bit word register and fold its bytes into the checksum. Lasts 1 cycle.
  - WORD: send the 4 latched bytes.
  - DONE: pulse `done`, clear `busy`. Lasts 1 cycle.
- `tx` is held high during the SEL, SETTLE and CAPTURE gaps.
- Consecutive bytes within HDR/PC/WORD/CHK are sent back-to-back, with no idle cycles.
- `start` is ignored while `busy` = 1. `start` is also ignored in the DONE cycle.
- `debug_inp` holds its last value (15) after the frame, and is set to 0 on reset.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `debug_inp`=0. FSM is in IDLE, checksum is 0, and the bit/baud counters are 0.
- Reset asserted mid-frame: on the next edge all outputs return to their reset values. `tx` goes high immediately, even mid-bit. The partial frame is abandoned and `done` does not pulse.
- Let C = `CLKS_PER_BIT`, S = `SETTLE_CYCLES`, with `start` sampled high at edge 0.
- Cycle 1:
  - `busy`=1.
  - `tx` falls, beginning the header start bit.
- Header occupies cycles 1..10C.
- PC bytes occupy the following 40C cycles.
- Each register slot takes S+2+40C cycles:
  - `debug_inp`=r from its SEL cycle through the end of its WORD.
  - `debug_out` is sampled in the CAPTURE cycle, exactly S+1 cycles after `debug_inp` changed.
- Checksum byte takes 10C cycles.
- `done`=1 and `busy`=0 in cycle 1 + 70·10C + 16(S+2). For C=4, S=2 this is cycle 2865.
- A new `start` can be accepted the cycle after DONE.
- Arithmetic:
  - Baud counter counts 0..C−1.
  - Bit index counts 0..9.
  - Byte index within a word counts 0..3.
  - Register index counts 0..15 and is 4 bits wide; it does not wrap, and the FSM exits to CHK after 15.

## Test plan
- Reset state: hold `reset` for 3 cycles, then release with `start`=0 for 50 cycles → `tx`=1, `busy`=0, `done`=0 and `debug_inp`=0 throughout.
- Full frame (C=4, S=2):
  - Stimulus: core model returns `debug_out` = 0x1000_0000 + `debug_inp` with 1-cycle latency; `fetchPC`=0x0000_0040; `start` pulsed at cycle 0.
  - Required response: UART monitor decodes A5 00 00 00 40 10 00 00 00 10 00 00 01 … 10 00 00 0F 40.
  - Required timing: `done` pulses at cycle 2865.
- Settle and capture: model makes `debug_out` valid only S cycles after a `debug_inp` change (X before that) → no X bits appear on `tx`. `debug_inp` steps 0→15 in order, with each value held for S+2+40C cycles.
- Ignored start and PC latch:
  - Stimulus: hold `start`=1 continuously; change `fetchPC` to 0xDEAD_BEEF at cycle 5.
  - Required response: the frame carries PC 00 00 00 40. Exactly one frame completes, then a second frame starts the cycle after DONE.
- Reset mid-frame: assert `reset` at cycle 500, mid-bit during the R1 word → `tx`=1 and `busy`=0 at cycle 501, and `done` never pulses. A fresh `start` afterwards produces a complete, correct 70-byte frame.
- Baud accuracy: with C=868, measure the start-bit low width of the header → exactly 868 cycles. Every bit of the frame also lasts exactly 868 cycles.

Source files
------------

// File: rtl/reg_dump_tx.sv
// Streams a snapshot of the core's fetch PC and R0..R15 over an 8N1 UART line,
// framed as 0xA5, PC, 16 register words and an XOR checksum of the payload.
module reg_dump_tx #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] debug_out,
    input  logic [31:0] fetchPC,
    output logic [3:0]  debug_inp,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, HDR, PC, SEL, SETTLE, CAPTURE, WORD, CHK, DONE
    } stateT;

    stateT             state;
    logic [BAUD_W-1:0] baudCnt;
    logic [3:0]        bitIdx;
    logic [1:0]        byteIdx;
    logic [3:0]        regIdx;
    logic [SET_W-1:0]  settleCnt;
    logic [7:0]        checksum;
    logic [31:0]       pcLatch;
    logic [31:0]       wordReg;
    logic [7:0]        curByte;
    logic              bitEnd;

    function automatic logic [7:0] wordByte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    wordByte = w[31:24];
            2'd1:    wordByte = w[23:16];
            2'd2:    wordByte = w[15:8];
            default: wordByte = w[7:0];
        endcase
    endfunction

    function automatic logic [7:0] foldWord(input logic [31:0] w);
        foldWord = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    assign bitEnd = (baudCnt == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            debug_inp <= 4'd0;
            checksum  <= 8'd0;
            baudCnt   <= '0;
            bitIdx    <= 4'd0;
            byteIdx   <= 2'd0;
            regIdx    <= 4'd0;
            settleCnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pcLatch  <= fetchPC;
                        checksum <= foldWord(fetchPC);
                        busy     <= 1'b1;
                        curByte  <= 8'hA5;
                        tx       <= 1'b0;
                        baudCnt  <= '0;
                        bitIdx   <= 4'd0;
                        state    <= HDR;
                    end
                end
                HDR, PC, WORD, CHK: begin
                    if (!bitEnd) begin
                        baudCnt <= baudCnt + BAUD_W'(1);
                    end else begin
                        baudCnt <= '0;
                        if (bitIdx != 4'd9) begin
                            // bitIdx 0 is the start bit, so data bit n goes out as bit n+1
                            bitIdx <= bitIdx + 4'd1;
                            tx     <= (bitIdx == 4'd8) ? 1'b1 : curByte[bitIdx[2:0]];
                        end else begin
                            bitIdx <= 4'd0;
                            case (state)
                                HDR: begin
                                    byteIdx <= 2'd0;
                                    curByte <= pcLatch[31:24];
                                    tx      <= 1'b0;
                                    state   <= PC;
                                end
                                PC: begin
                                    if (byteIdx == 2'd3) begin
                                        regIdx    <= 4'd0;
                                        debug_inp <= 4'd0;
                                        tx        <= 1'b1;
                                        state     <= SEL;
                                    end else begin
                                        byteIdx <= byteIdx + 2'd1;
                                        curByte <= wordByte(pcLatch, byteIdx + 2'd1);
                                        tx      <= 1'b0;
                                    end
                                end
                                WORD: begin
                                    if (byteIdx != 2'd3) begin
                                        byteIdx <= byteIdx + 2'd1;
                                        curByte <= wordByte(wordReg, byteIdx + 2'd1);
                                        tx      <= 1'b0;
                                    end else if (regIdx == 4'd15) begin
                                        curByte <= checksum;
                                        tx      <= 1'b0;
                                        state   <= CHK;
                                    end else begin
                                        regIdx    <= regIdx + 4'd1;
                                        debug_inp <= regIdx + 4'd1;
                                        tx        <= 1'b1;
                                        state     <= SEL;
                                    end
                                end
                                default: begin
                                    tx    <= 1'b1;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= DONE;
                                end
                            endcase
                        end
                    end
                end
                SEL: begin
                    settleCnt <= '0;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    if (settleCnt == SET_W'(SETTLE_CYCLES - 1)) begin
                        state <= CAPTURE;
                    end else begin
                        settleCnt <= settleCnt + SET_W'(1);
                    end
                end
                CAPTURE: begin
                    // debug_inp has been stable for SETTLE_CYCLES+1 cycles here
                    wordReg  <= debug_out;
                    checksum <= checksum ^ foldWord(debug_out);
                    curByte  <= debug_out[31:24];
                    byteIdx  <= 2'd0;
                    baudCnt  <= '0;
                    bitIdx   <= 4'd0;
                    tx       <= 1'b0;
                    state    <= WORD;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
